// File: rtl/cnn_fc_pkg.sv
// rtl/cnn_fc_pkg.sv - shared types, default layout and result saturation for the FC layer sequencer
package cnn_fc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_X,
    ST_RD_W,
    ST_MAC,
    ST_WR,
    ST_DONE
  } fc_state_t;

  localparam int DEF_FRT_CELL = 10;
  localparam int DEF_BCK_CELL = 5;
  localparam int DEF_X_BASE   = 0;
  localparam int SAT_IN_W     = 64;

  // Weights sit right after the inputs; outputs right after the weight block.
  function automatic int def_w_base(input int frt_cell);
    return frt_cell;
  endfunction

  function automatic int def_out_base(input int frt_cell, input int bck_cell);
    return frt_cell * (bck_cell + 1);
  endfunction

  // Accumulator values arrive sign-extended to SAT_IN_W bits.
  function automatic logic signed [15:0] sat16(input logic signed [SAT_IN_W-1:0] v,
                                               input logic relu);
    logic signed [15:0] r;
    if (v > 64'sd32767)
      r = 16'sh7fff;
    else if (v < -64'sd32768)
      r = 16'sh8000;
    else
      r = v[15:0];
    if (relu && r[15])
      r = '0;
    return r;
  endfunction

endpackage

// File: rtl/fc_mac_unit.sv
// rtl/fc_mac_unit.sv - signed 16x16 multiply feeding a clearable ACC_W-bit accumulator
module fc_mac_unit #(
  parameter int ACC_W = 40
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    clr,
  input  logic                    en,
  input  logic signed [15:0]      a,
  input  logic signed [15:0]      b,
  output logic signed [ACC_W-1:0] acc
);

  logic signed [31:0] prod;

  assign prod = a * b;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      acc <= '0;
    else if (clr)
      acc <= '0;
    else if (en)
      acc <= acc + ACC_W'(prod);
  end

endmodule

// File: rtl/fc_layer_seq.sv
// rtl/fc_layer_seq.sv - fully-connected layer sequencer driving the shared weight/activation RAM
module fc_layer_seq
  import cnn_fc_pkg::*;
#(
  parameter int FRT_CELL  = DEF_FRT_CELL,
  parameter int BCK_CELL  = DEF_BCK_CELL,
  parameter int X_BASE    = DEF_X_BASE,
  parameter int W_BASE    = def_w_base(FRT_CELL),
  parameter int OUT_BASE  = def_out_base(FRT_CELL, BCK_CELL),
  parameter int FRAC_BITS = 0,
  parameter int RELU      = 0,
  parameter int ACC_W     = 40
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  input  logic [15:0] host_addr,
  input  logic [15:0] host_data,
  input  logic        host_we,
  output logic [15:0] host_q,
  output logic [15:0] ram_addr,
  output logic [15:0] ram_data,
  output logic        ram_we,
  input  logic [15:0] ram_q
);

  localparam int IW = $clog2(FRT_CELL) + 1;
  localparam int JW = $clog2(BCK_CELL) + 1;
  localparam logic [IW-1:0] I_LAST = IW'(FRT_CELL - 1);
  localparam logic [JW-1:0] J_LAST = JW'(BCK_CELL - 1);

  fc_state_t state, state_nx;

  logic [IW-1:0]           i;
  logic [JW-1:0]           j;
  logic signed [15:0]      x_reg;
  logic                    mac_clr;
  logic                    mac_en;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] shifted;
  logic signed [15:0]      result;
  logic [15:0]             x_addr;
  logic [15:0]             w_addr;
  logic [15:0]             out_addr;

  assign host_q   = ram_q;
  assign x_addr   = 16'(X_BASE) + 16'(i);
  assign w_addr   = 16'(W_BASE) + 16'(j) * 16'(FRT_CELL) + 16'(i);
  assign out_addr = 16'(OUT_BASE) + 16'(j);
  assign shifted  = acc >>> FRAC_BITS;
  assign result   = sat16(SAT_IN_W'(shifted), RELU != 0);

  fc_mac_unit #(
    .ACC_W (ACC_W)
  ) u_mac (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (mac_clr),
    .en      (mac_en),
    .a       (x_reg),
    .b       (ram_q),
    .acc     (acc)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state <= ST_IDLE;
    else
      state <= state_nx;
  end

  // Only IDLE hands the RAM port to the host; every other state owns it.
  always_comb begin
    state_nx = state;
    busy     = 1'b1;
    done     = 1'b0;
    mac_clr  = 1'b0;
    mac_en   = 1'b0;
    ram_addr = host_addr;
    ram_data = host_data;
    ram_we   = host_we;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_nx = ST_RD_X;
          mac_clr  = 1'b1;
        end
      end
      ST_RD_X: begin
        ram_addr = x_addr;
        ram_data = '0;
        ram_we   = 1'b0;
        state_nx = ST_RD_W;
      end
      ST_RD_W: begin
        ram_addr = w_addr;
        ram_data = '0;
        ram_we   = 1'b0;
        state_nx = ST_MAC;
      end
      ST_MAC: begin
        // Counters are unchanged since RD_W, so w_addr is the held address.
        ram_addr = w_addr;
        ram_data = '0;
        ram_we   = 1'b0;
        mac_en   = 1'b1;
        state_nx = (i == I_LAST) ? ST_WR : ST_RD_X;
      end
      ST_WR: begin
        ram_addr = out_addr;
        ram_data = result;
        ram_we   = 1'b1;
        mac_clr  = 1'b1;
        state_nx = (j == J_LAST) ? ST_DONE : ST_RD_X;
      end
      ST_DONE: begin
        done     = 1'b1;
        ram_data = '0;
        ram_we   = 1'b0;
        state_nx = ST_IDLE;
      end
      default: begin
        ram_we   = 1'b0;
        state_nx = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      i     <= '0;
      j     <= '0;
      x_reg <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            i <= '0;
            j <= '0;
          end
        end
        ST_RD_W: x_reg <= ram_q;
        ST_MAC: begin
          if (i != I_LAST)
            i <= i + 1'b1;
        end
        ST_WR: begin
          i <= '0;
          if (j != J_LAST)
            j <= j + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fc_layer_seq.sv
// tb/tb_fc_layer_seq.sv - self-checking bench for fc_layer_seq with four parameterisations
module tb_fc_layer_seq;

  typedef struct {
    int inst;
    int addr;
    int exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [3:0]  mask;
  logic [15:0] host_addr;
  logic [15:0] host_data;
  logic        host_we;

  logic [3:0]  busy_v;
  logic [3:0]  done_v;
  logic [3:0]  ram_we_v;
  logic [15:0] host_q_v   [4];
  logic [15:0] ram_addr_v [4];
  logic [15:0] ram_data_v [4];
  logic [15:0] ram_q_v    [4];

  logic [15:0] mem  [4][128];
  logic [6:0]  areg [4];

  int done_cnt [4];
  int busy_cnt0;
  int n_err;
  int n_chk;

  always #5 clk = ~clk;

  // Instance 0: defaults; 1: RELU; 2: FRAC_BITS=4; 3: FRT_CELL=BCK_CELL=1.
  for (genvar k = 0; k < 4; k++) begin : g_dut
    fc_layer_seq #(
      .FRT_CELL  (k == 3 ? 1 : 10),
      .BCK_CELL  (k == 3 ? 1 : 5),
      .FRAC_BITS (k == 2 ? 4 : 0),
      .RELU      (k == 1 ? 1 : 0)
    ) u_dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .start     (start & mask[k]),
      .busy      (busy_v[k]),
      .done      (done_v[k]),
      .host_addr (host_addr),
      .host_data (host_data),
      .host_we   (host_we & mask[k]),
      .host_q    (host_q_v[k]),
      .ram_addr  (ram_addr_v[k]),
      .ram_data  (ram_data_v[k]),
      .ram_we    (ram_we_v[k]),
      .ram_q     (ram_q_v[k])
    );
    assign ram_q_v[k] = mem[k][areg[k]];
  end

  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (ram_we_v[k])
        mem[k][ram_addr_v[k][6:0]] <= ram_data_v[k];
      areg[k] <= ram_addr_v[k][6:0];
    end
  end

  initial begin
    for (int k = 0; k < 4; k++) done_cnt[k] = 0;
    busy_cnt0 = 0;
  end

  always @(negedge clk) begin
    for (int k = 0; k < 4; k++)
      if (done_v[k]) done_cnt[k] <= done_cnt[k] + 1;
    if (busy_v[0]) busy_cnt0 <= busy_cnt0 + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic host_wr(input logic [3:0] m, input int a, input int d);
    mask      = m;
    host_addr = 16'(a);
    host_data = 16'(d);
    host_we   = 1'b1;
    tick();
    host_we   = 1'b0;
  endtask

  task automatic host_rd(input int k, input int a, output int v);
    host_addr = 16'(a);
    tick();
    v = int'($signed(host_q_v[k]));
  endtask

  // Pulses start on the masked instances and waits for done on instance k.
  task automatic run(input logic [3:0] m, input int k, output int lat);
    mask  = m;
    start = 1'b1;
    tick();
    start = 1'b0;
    lat   = 0;
    while (!done_v[k] && lat < 400) begin
      tick();
      lat++;
    end
    if (!done_v[k]) begin
      n_chk++;
      n_err++;
      $display("FAIL run_timeout inst %0d: got no done, expected done within 400 cycles", k);
    end
    tick();
  endtask

  vec_t vecs[$];
  int   v;
  int   lat;
  int   d0 [4];
  int   b0;

  initial begin
    n_err     = 0;
    n_chk     = 0;
    reset_n   = 1'b0;
    start     = 1'b0;
    mask      = 4'h0;
    host_addr = '0;
    host_data = '0;
    host_we   = 1'b0;
    repeat (3) tick();

    check("reset_busy", int'(busy_v), 0);
    check("reset_done", int'(done_v), 0);
    mask    = 4'hF;
    host_we = 1'b1;
    #1;
    check("reset_we_follows_host", int'(ram_we_v), 15);
    host_we = 1'b0;
    #1;
    check("reset_we_follows_host_low", int'(ram_we_v), 0);
    reset_n = 1'b1;
    tick();

    for (int k = 0; k < 50; k++) host_wr(4'b0111, 10 + k, -250 + 10 * k);
    for (int k = 0; k < 10; k++) host_wr(4'b0111, k, 1);
    host_wr(4'b1000, 1, -250);
    host_wr(4'b1000, 0, 1);

    for (int k = 0; k < 4; k++) d0[k] = done_cnt[k];
    b0 = busy_cnt0;
    run(4'b1111, 0, lat);
    check("done_latency", lat, 155);
    check("busy_cycles", busy_cnt0 - b0, 156);
    for (int k = 0; k < 4; k++) check($sformatf("done_pulses_inst%0d", k), done_cnt[k] - d0[k], 1);
    check("idle_after_done", int'(busy_v), 0);

    vecs.push_back('{0, 60, -2050});
    vecs.push_back('{0, 61, -1050});
    vecs.push_back('{0, 62, -50});
    vecs.push_back('{0, 63, 950});
    vecs.push_back('{0, 64, 1950});
    vecs.push_back('{1, 60, 0});
    vecs.push_back('{1, 61, 0});
    vecs.push_back('{1, 62, 0});
    vecs.push_back('{1, 63, 950});
    vecs.push_back('{1, 64, 1950});
    vecs.push_back('{2, 60, -129});
    vecs.push_back('{2, 62, -4});
    vecs.push_back('{2, 64, 121});
    vecs.push_back('{3, 2, -250});
    vecs.push_back('{0, 10, -250});
    for (int n = 0; n < vecs.size(); n++) begin
      host_rd(vecs[n].inst, vecs[n].addr, v);
      check($sformatf("y_inst%0d_addr%0d", vecs[n].inst, vecs[n].addr), v, vecs[n].exp);
    end

    for (int k = 0; k < 10; k++) host_wr(4'b0001, k, 1000);
    run(4'b0001, 0, lat);
    host_rd(0, 60, v); check("sat_y0", v, -32768);
    host_rd(0, 62, v); check("sat_y2", v, -32768);
    host_rd(0, 63, v); check("sat_y3", v, 32767);
    host_rd(0, 64, v); check("sat_y4", v, 32767);

    for (int k = 0; k < 10; k++) host_wr(4'b0001, k, 1);
    d0[0] = done_cnt[0];
    mask  = 4'b0001;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (100) tick();
    host_addr = 16'd60;
    host_data = 16'h1234;
    host_we   = 1'b1;
    start     = 1'b1;
    #1;
    check("busy_host_we_dropped", int'(ram_we_v[0]), 0);
    tick();
    host_we = 1'b0;
    start   = 1'b0;
    lat     = 0;
    while (!done_v[0] && lat < 400) begin
      tick();
      lat++;
    end
    check("busy_run_done_seen", int'(done_v[0]), 1);
    repeat (5) tick();
    check("restart_ignored_single_done", done_cnt[0] - d0[0], 1);
    check("restart_ignored_idle", int'(busy_v[0]), 0);
    host_rd(0, 60, v); check("busy_write_blocked_y0", v, -2050);

    for (int k = 62; k < 65; k++) host_wr(4'b0001, k, 16'h7777);
    d0[0] = done_cnt[0];
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (75) tick();
    reset_n = 1'b0;
    #1;
    check("abort_busy", int'(busy_v[0]), 0);
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (3) tick();
    check("abort_no_done", done_cnt[0] - d0[0], 0);
    host_rd(0, 61, v); check("abort_kept_y1", v, -1050);
    host_rd(0, 62, v); check("abort_unwritten_y2", v, 16'h7777);
    run(4'b0001, 0, lat);
    check("rerun_latency", lat, 155);
    host_rd(0, 62, v); check("rerun_y2", v, -50);
    host_rd(0, 63, v); check("rerun_y3", v, 950);
    host_rd(0, 64, v); check("rerun_y4", v, 1950);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/fc_layer_seq.md
Name: fc_layer_seq

Overview:
- Fully-connected layer sequencer that sits directly downstream of the shared 16-bit weight/activation RAM and drives that RAM's data/addr/we port.
- Reads FRT_CELL input activations and FRT_CELL*BCK_CELL weights, and computes BCK_CELL signed dot products.
- Shifts, saturates and optionally ReLUs each result, then writes the BCK_CELL outputs back into the RAM.
- While idle, the RAM port is passed through to a host port so inputs can be loaded and results read back.

Parameters:
- FRT_CELL, 10, inputs per neuron.
- BCK_CELL, 5, output neurons.
- X_BASE, 0, RAM address of input x[0].
- W_BASE, FRT_CELL, RAM address of w[0][0]; weight for neuron j, input i is at W_BASE + j*FRT_CELL + i.
- OUT_BASE, FRT_CELL*(BCK_CELL+1), RAM address of output y[0].
- FRAC_BITS, 0, arithmetic right shift applied to the accumulator before saturation.
- RELU, 0, 1 = clamp negative results to 0.
- ACC_W, 40, signed accumulator width.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- busy  out  1  high from the cycle after start is accepted until DONE completes.
- done  out  1  one-cycle pulse in the DONE state.
- host_addr  in  16  host RAM address (used when busy=0).
- host_data  in  16  host write data.
- host_we  in  1  host write enable; dropped while busy=1.
- host_q  out  16  equals ram_q at all times.
- ram_addr  out  16  to RAM addr.
- ram_data  out  16  to RAM data.
- ram_we  out  1  to RAM we.
- ram_q  in  16  from RAM q. Valid one cycle after the address is presented: the RAM registers the address, and q reads combinationally from the registered address.

Behaviour:
- Reset (async): state=IDLE, i=0, j=0, acc=0, x_reg=0, busy=0, done=0.
  - The RAM port falls back to the host mux, so ram_we follows host_we.
  - Reset mid-operation aborts the layer and issues no done. Outputs already written stay in RAM.
- FSM states: IDLE, RD_X, RD_W, MAC, WR, DONE. ram_addr/ram_we/ram_data are combinational from state and counters.
- IDLE:
  - RAM port = host port.
  - start=1 at an edge → RD_X with i=0, j=0, acc=0.
  - start while busy is ignored.
- RD_X: ram_addr = X_BASE+i, ram_we=0 → RD_W.
- RD_W: ram_addr = W_BASE + j*FRT_CELL + i; x_reg <= ram_q → MAC.
- MAC: ram_we=0, ram_addr holds its last value.
  - acc <= acc + sext(x_reg*ram_q), using a signed 16x16 → 32-bit product.
  - If i==FRT_CELL-1: go to WR. Otherwise i++ and go to RD_X.
- WR: ram_we=1, ram_addr = OUT_BASE+j, ram_data = result.
  - acc <= 0, i <= 0.
  - If j==BCK_CELL-1: go to DONE. Otherwise j++ and go to RD_X.
- result:
  - s = acc >>> FRAC_BITS (arithmetic shift).
  - Saturate s to [-32768, 32767].
  - If RELU=1 and the saturated value is negative, result = 0.
- DONE: done=1 for one cycle → IDLE.
  - A start pulse in the DONE cycle is ignored; start is re-accepted from IDLE.
- Latency:
  - Each neuron takes 3*FRT_CELL + 1 cycles.
  - The layer is busy for BCK_CELL*(3*FRT_CELL+1) + 1 cycles, which is 156 with the defaults.
  - done is high in the cycle after edge BCK_CELL*(3*FRT_CELL+1), counting the start-sampling edge as edge 0.
- Accumulator: no internal overflow for ACC_W ≥ 32 + clog2(FRT_CELL).
- Boundaries:
  - FRT_CELL=1 and BCK_CELL=1 must work.
  - Counters are sized clog2(param) + 1.

Decomposition:
- Package cnn_fc_pkg holds:
  - state enum;
  - X_BASE/W_BASE/OUT_BASE defaults;
  - a sat16 function (signed ACC_W → 16 with optional ReLU).
- One sub-module, fc_mac_unit: signed 16x16 multiply, ACC_W accumulator with clear and enable inputs, exposing acc.

Test Plan:
- Weights = RAM reset image (w at address FRT_CELL+k = -250+10k); host writes x[0..9]=1; start (RELU=0, FRAC_BITS=0) → RAM[60..64] = -2050, -1050, -50, 950, 1950; done after 156 busy cycles.
- Same stimulus with RELU=1 → RAM[60..64] = 0, 0, 0, 950, 1950.
- x[0..9]=1000 → y[0]=-32768 and y[4]=32767 (saturated); y[2]=-32768 (-50000 saturates).
- FRAC_BITS=4 with x=1 → y[4] = 1950>>>4 = 121; y[0] = -2050>>>4 = -129.
- host_we pulsed to address 60 while busy → no write occurs; start re-pulsed while busy → ignored, a single done pulse.
- reset_n asserted during neuron 2 → busy=0, no done; new start afterwards → correct full results.
